// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - pipeline <-> CP0 exception controller signal bundle
interface cp0_exc_ctrl_if;
    logic        cpr_we;
    logic [4:0]  cpr_waddr;
    logic [31:0] cpr_wdata;
    logic [4:0]  cpr_raddr;
    logic [31:0] cpr_rdata;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] epc_in;
    logic        eret_req;
    logic [5:0]  int_req;
    logic        busy;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;

    // Pipeline side: issues mtc0/mfc0 and exception/eret requests
    modport master (
        output cpr_we, cpr_waddr, cpr_wdata, cpr_raddr,
        output exc_req, exc_code, epc_in, eret_req, int_req,
        input  cpr_rdata, busy, flush, redirect, redirect_pc
    );

    // CP0 side: owns Status/Cause/EPC and the exception sequencer
    modport slave (
        input  cpr_we, cpr_waddr, cpr_wdata, cpr_raddr,
        input  exc_req, exc_code, epc_in, eret_req, int_req,
        output cpr_rdata, busy, flush, redirect, redirect_pc
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 Status/Cause/EPC with exception/interrupt/eret sequencer
module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h00000180
) (
    input  logic               clk,
    input  logic               rst_n,
    cp0_exc_ctrl_if.slave      bus
);
    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_SAVE, S_REDIRECT} state_t;
    typedef enum logic [1:0] {K_EXC, K_INT, K_ERET} kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    logic [4:0]  lcode_q, lcode_d;
    logic [31:0] lpc_q, lpc_d;
    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic [5:0]  im_q, im_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [5:0]  ip_q, ip_d;
    logic [31:0] epc_q, epc_d;
    logic        busy_q, busy_d;
    logic        flush_q, flush_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        int_pending;
    logic        start;
    logic        wr_ok;
    logic [31:0] status_val;
    logic [31:0] cause_val;

    assign int_pending = (|(ip_q & im_q)) && ie_q && !exl_q;
    assign start       = bus.exc_req || int_pending || bus.eret_req;
    // mtc0 only lands in an idle cycle that is not also starting a sequence
    assign wr_ok       = bus.cpr_we && (state_q == S_IDLE) && !start;

    assign status_val  = {16'h0, im_q, 8'h0, exl_q, ie_q};
    assign cause_val   = {16'h0, ip_q, 3'b0, exccode_q, 2'b0};

    // mfc0 read path with same-cycle bypass of an accepted mtc0
    always_comb begin
        bus.cpr_rdata = 32'h0;
        case (bus.cpr_raddr)
            REG_STATUS: begin
                if (wr_ok && bus.cpr_waddr == REG_STATUS)
                    bus.cpr_rdata = {16'h0, bus.cpr_wdata[15:10], 8'h0, bus.cpr_wdata[1:0]};
                else
                    bus.cpr_rdata = status_val;
            end
            REG_CAUSE: bus.cpr_rdata = cause_val;
            REG_EPC: begin
                if (wr_ok && bus.cpr_waddr == REG_EPC)
                    bus.cpr_rdata = bus.cpr_wdata;
                else
                    bus.cpr_rdata = epc_q;
            end
            default: bus.cpr_rdata = 32'h0;
        endcase
    end

    // Next-state, register updates and registered sequencer outputs
    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        lcode_d       = lcode_q;
        lpc_d         = lpc_q;
        ie_d          = ie_q;
        exl_d         = exl_q;
        im_d          = im_q;
        exccode_d     = exccode_q;
        epc_d         = epc_q;
        ip_d          = bus.int_req;

        case (state_q)
            S_IDLE: begin
                if (bus.exc_req) begin
                    kind_d  = K_EXC;
                    lcode_d = bus.exc_code;
                    lpc_d   = bus.epc_in;
                    state_d = S_FLUSH;
                end else if (int_pending) begin
                    kind_d  = K_INT;
                    lcode_d = 5'd0;
                    lpc_d   = bus.epc_in;
                    state_d = S_FLUSH;
                end else if (bus.eret_req) begin
                    kind_d  = K_ERET;
                    lcode_d = 5'd0;
                    lpc_d   = bus.epc_in;
                    state_d = S_FLUSH;
                end else if (wr_ok) begin
                    if (bus.cpr_waddr == REG_STATUS) begin
                        ie_d  = bus.cpr_wdata[0];
                        exl_d = bus.cpr_wdata[1];
                        im_d  = bus.cpr_wdata[15:10];
                    end else if (bus.cpr_waddr == REG_EPC) begin
                        epc_d = bus.cpr_wdata;
                    end
                end
            end
            S_FLUSH: state_d = S_SAVE;
            S_SAVE: begin
                if (kind_q == K_ERET) begin
                    exl_d = 1'b0;
                end else begin
                    epc_d     = lpc_q;
                    exccode_d = lcode_q;
                    exl_d     = 1'b1;
                end
                state_d = S_REDIRECT;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d        = (state_d != S_IDLE);
        flush_d       = (state_d == S_FLUSH);
        redirect_d    = (state_d == S_REDIRECT);
        redirect_pc_d = 32'h0;
        if (state_d == S_REDIRECT)
            redirect_pc_d = (kind_q == K_ERET) ? epc_q : EXC_VECTOR;
    end

    // State and register storage; reset abandons any sequence in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            kind_q        <= K_EXC;
            lcode_q       <= 5'd0;
            lpc_q         <= 32'h0;
            ie_q          <= 1'b0;
            exl_q         <= 1'b0;
            im_q          <= 6'd0;
            exccode_q     <= 5'd0;
            ip_q          <= 6'd0;
            epc_q         <= 32'h0;
            busy_q        <= 1'b0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            lcode_q       <= lcode_d;
            lpc_q         <= lpc_d;
            ie_q          <= ie_d;
            exl_q         <= exl_d;
            im_q          <= im_d;
            exccode_q     <= exccode_d;
            ip_q          <= ip_d;
            epc_q         <= epc_d;
            busy_q        <= busy_d;
            flush_q       <= flush_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.flush       = flush_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - scoreboard bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic [31:0] exp_q[$];

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl #(.EXC_VECTOR(32'h00000180)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Redirect monitor: every redirect pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (rst_n && bus.redirect === 1'b1) begin
            if (exp_q.size() == 0)
                check("unexpected_redirect", 32'd1, 32'd0);
            else
                check("redirect_pc", bus.redirect_pc, exp_q.pop_front());
        end
    end

    task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        bus.cpr_raddr = addr;
        #1;
        check(tag, bus.cpr_rdata, exp);
    endtask

    // Request driven in the current cycle; walk FLUSH, SAVE, REDIRECT, IDLE
    task automatic run_seq(input string tag);
        @(negedge clk);
        bus.exc_req  = 1'b0;
        bus.eret_req = 1'b0;
        bus.cpr_we   = 1'b0;
        check({tag, "_flush1"}, {31'd0, bus.flush}, 32'd1);
        check({tag, "_busy1"},  {31'd0, bus.busy},  32'd1);
        @(negedge clk);
        check({tag, "_busy2"},  {31'd0, bus.busy},  32'd1);
        check({tag, "_flush2"}, {31'd0, bus.flush}, 32'd0);
        check({tag, "_redir2"}, {31'd0, bus.redirect}, 32'd0);
        @(negedge clk);
        check({tag, "_redir3"}, {31'd0, bus.redirect}, 32'd1);
        check({tag, "_busy3"},  {31'd0, bus.busy},  32'd1);
        @(negedge clk);
        check({tag, "_busy4"},  {31'd0, bus.busy},  32'd0);
        check({tag, "_redir4"}, {31'd0, bus.redirect}, 32'd0);
    endtask

    initial begin
        int busy_seen;
        n_checks = 0;
        n_errors = 0;
        bus.cpr_we    = 1'b0;
        bus.cpr_waddr = 5'd0;
        bus.cpr_wdata = 32'h0;
        bus.cpr_raddr = 5'd0;
        bus.exc_req   = 1'b0;
        bus.exc_code  = 5'd0;
        bus.epc_in    = 32'h0;
        bus.eret_req  = 1'b0;
        bus.int_req   = 6'd0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy",  {31'd0, bus.busy},     32'd0);
        check("rst_flush", {31'd0, bus.flush},    32'd0);
        check("rst_redir", {31'd0, bus.redirect}, 32'd0);
        check("rst_rpc",   bus.redirect_pc,       32'h0);
        rd("rst_status", 5'd12, 32'h0);
        rd("rst_cause",  5'd13, 32'h0);
        rd("rst_epc",    5'd14, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", {31'd0, bus.busy}, 32'd0);

        // Synchronous exception
        bus.exc_req  = 1'b1;
        bus.exc_code = 5'd8;
        bus.epc_in   = 32'h00400020;
        exp_q.push_back(32'h00000180);
        run_seq("exc");
        rd("exc_epc",    5'd14, 32'h00400020);
        rd("exc_cause",  5'd13, 32'h00000020);
        rd("exc_status", 5'd12, 32'h00000002);

        // mtc0 EPC with same-cycle mfc0 bypass
        bus.cpr_we    = 1'b1;
        bus.cpr_waddr = 5'd14;
        bus.cpr_wdata = 32'hDEADBEEF;
        rd("bypass_epc", 5'd14, 32'hDEADBEEF);
        @(negedge clk);
        bus.cpr_we = 1'b0;
        rd("stored_epc", 5'd14, 32'hDEADBEEF);

        // Cause is read-only
        bus.cpr_we    = 1'b1;
        bus.cpr_waddr = 5'd13;
        bus.cpr_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus.cpr_we = 1'b0;
        rd("cause_ro", 5'd13, 32'h00000020);
        rd("unmapped", 5'd9, 32'h0);

        // Enable IM0/IE, clearing EXL
        bus.cpr_we    = 1'b1;
        bus.cpr_waddr = 5'd12;
        bus.cpr_wdata = 32'h00000401;
        rd("bypass_status", 5'd12, 32'h00000401);
        @(negedge clk);
        bus.cpr_we = 1'b0;
        rd("status_wr", 5'd12, 32'h00000401);

        // Interrupt: IP sampled one edge, accepted the next
        bus.int_req = 6'b000001;
        bus.epc_in  = 32'h00400024;
        @(negedge clk);
        check("int_latency_busy", {31'd0, bus.busy}, 32'd0);
        rd("int_cause_ip", 5'd13, 32'h00000420);
        exp_q.push_back(32'h00000180);
        run_seq("int");
        rd("int_epc",    5'd14, 32'h00400024);
        rd("int_cause",  5'd13, 32'h00000400);
        rd("int_status", 5'd12, 32'h00000403);
        busy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.busy) busy_seen++;
        end
        check("int_no_restart", busy_seen, 32'd0);
        bus.int_req = 6'd0;
        @(negedge clk);

        // eret returns to EPC and clears EXL
        bus.eret_req = 1'b1;
        bus.epc_in   = 32'h0;
        exp_q.push_back(32'h00400024);
        run_seq("eret");
        rd("eret_status", 5'd12, 32'h00000401);

        // Simultaneous exc, eret and mtc0: exception wins, write dropped
        bus.exc_req   = 1'b1;
        bus.exc_code  = 5'd12;
        bus.epc_in    = 32'h00400100;
        bus.eret_req  = 1'b1;
        bus.cpr_we    = 1'b1;
        bus.cpr_waddr = 5'd14;
        bus.cpr_wdata = 32'h12345678;
        rd("no_bypass_on_start", 5'd14, 32'h00400024);
        exp_q.push_back(32'h00000180);
        run_seq("combo");
        rd("combo_epc",    5'd14, 32'h00400100);
        rd("combo_cause",  5'd13, 32'h00000030);
        rd("combo_status", 5'd12, 32'h00000403);

        // Reset asserted during SAVE abandons the sequence
        bus.exc_req  = 1'b1;
        bus.exc_code = 5'd4;
        bus.epc_in   = 32'h00400200;
        @(negedge clk);
        bus.exc_req = 1'b0;
        check("rst_seq_flush", {31'd0, bus.flush}, 32'd1);
        @(negedge clk);
        check("rst_seq_save_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",  {31'd0, bus.busy},     32'd0);
        check("midrst_redir", {31'd0, bus.redirect}, 32'd0);
        rd("midrst_epc",    5'd14, 32'h0);
        rd("midrst_status", 5'd12, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.busy || bus.redirect) busy_seen++;
        end
        check("post_rst_quiet", busy_seen, 32'd0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 The block SHALL have one parameter: EXC_VECTOR, default 32'h00000180, exception entry PC.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port cpr_we, input, 1 bit: mtc0 write strobe from the Wr stage.
REQ-005 The block SHALL have port cpr_waddr, input, 5 bits: mtc0 target register number.
REQ-006 The block SHALL have port cpr_wdata, input, 32 bits: mtc0 write data.
REQ-007 The block SHALL have port cpr_raddr, input, 5 bits: mfc0 source register number.
REQ-008 The block SHALL have port cpr_rdata, output, 32 bits: mfc0 read data, combinational.
REQ-009 The block SHALL have port exc_req, input, 1 bit: synchronous exception request (e.g. syscall).
REQ-010 The block SHALL have port exc_code, input, 5 bits: ExcCode for exc_req.
REQ-011 The block SHALL have port epc_in, input, 32 bits: restart PC of the faulting or interrupted instruction.
REQ-012 The block SHALL have port eret_req, input, 1 bit: eret request.
REQ-013 The block SHALL have port int_req, input, 6 bits: external interrupt lines, level-sensitive.
REQ-014 The block SHALL have port busy, output, 1 bit: sequence in progress; the pipeline holds.
REQ-015 The block SHALL have port flush, output, 1 bit: single-cycle pipeline flush pulse.
REQ-016 The block SHALL have port redirect, output, 1 bit: single-cycle PC redirect pulse.
REQ-017 The block SHALL have port redirect_pc, output, 32 bits: target PC, valid while redirect=1.

Function
REQ-018 The block SHALL hold three registers: Status (reg 12; bit0 IE, bit1 EXL, bits15:10 IM), Cause (reg 13; bits6:2 ExcCode, bits15:10 IP), and EPC (reg 14, 32 bits); all unlisted bits SHALL read 0.
REQ-019 Cause.IP SHALL load int_req on every clock edge in every state, giving a 1-cycle sampling latency.
REQ-020 An interrupt SHALL be pending when (Cause.IP & Status.IM)!=0 && IE==1 && EXL==0.
REQ-021 The FSM SHALL have states IDLE, FLUSH, SAVE and REDIRECT; busy=1 in every state except IDLE.
REQ-022 In IDLE, start-request priority SHALL be exc_req > pending interrupt > eret_req; the winner SHALL be latched as kind (EXC/INT/ERET), with exc_code (0 for INT) and epc_in, and the FSM SHALL go to FLUSH.
REQ-023 FLUSH SHALL assert flush=1 for one cycle, then go to SAVE.
REQ-024 SAVE SHALL, for EXC/INT: set EPC to the latched PC, Cause.ExcCode to the latched code, and EXL to 1.
REQ-025 SAVE SHALL, for ERET: clear EXL. SAVE then goes to REDIRECT.
REQ-026 REDIRECT SHALL assert redirect=1 for one cycle, then go to IDLE.
REQ-027 In REDIRECT, redirect_pc SHALL be EXC_VECTOR for EXC/INT and the current EPC for ERET; otherwise redirect_pc=0.
REQ-028 Each sequence SHALL take exactly 3 busy cycles after the accepting edge; a new request SHALL be accepted in the first IDLE cycle after REDIRECT.
REQ-029 mtc0 SHALL write only in IDLE with no start request in that cycle: reg 12 writes IE, EXL and IM; reg 14 writes EPC; Cause and other addresses are read-only/ignored.
REQ-030 Start requests and cpr_we arriving while busy=1 SHALL be dropped, not queued; a simultaneous exc_req and cpr_we in IDLE SHALL drop the write.
REQ-031 cpr_rdata SHALL bypass: if cpr_we=1 and cpr_waddr==cpr_raddr names a writable register, and the write is accepted this cycle, return the post-write value; otherwise return the stored value; unmapped addresses return 0.

Reset
REQ-032 On rst_n=0 (asynchronous, active-low, including mid-sequence) the block SHALL immediately set state=IDLE and Status, Cause, EPC, latched kind/code/PC to 0, and busy, flush, redirect, redirect_pc to 0.
REQ-033 After rst_n rises, no sequence SHALL start until a request is sampled on a clock edge.

Verification
REQ-034 The bench SHALL cover: exc_req=1, exc_code=8, epc_in=32'h00400020 in IDLE -> flush at +1, redirect at +3 with redirect_pc=32'h00000180; then EPC=32'h00400020, ExcCode=8, EXL=1.
REQ-035 The bench SHALL cover: mtc0 Status=32'h0000_0401 (IE=1, IM0=1), then int_req=6'b000001 -> sequence starts 2 edges later with ExcCode=0; while EXL=1, int_req held high does not restart.
REQ-036 The bench SHALL cover: eret_req with EPC=32'h00400024, EXL=1 -> redirect_pc=32'h00400024 at +3, EXL=0 after SAVE.
REQ-037 The bench SHALL cover: exc_req, eret_req and cpr_we (reg 14) all in the same IDLE cycle -> EXC sequence runs, EPC=epc_in, the write is dropped, and eret is ignored.
REQ-038 The bench SHALL cover: cpr_we=1 to reg 14 with data 32'hDEADBEEF and cpr_raddr=14 in the same cycle -> cpr_rdata=32'hDEADBEEF combinationally.
REQ-039 The bench SHALL cover: rst_n low during SAVE -> busy=0 and state=IDLE immediately, EPC=0, and no redirect pulse.
